// File: rtl/axi3_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : axi3_pkg                                                   |
// | Purpose  : AXI3 field types, low-power FSM states, payload widths.    |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
package axi3_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_t;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_t;

    typedef enum logic [1:0] {
        LOCK_NORMAL = 2'b00,
        LOCK_EXCL   = 2'b01,
        LOCK_LOCKED = 2'b10,
        LOCK_RSVD   = 2'b11
    } lock_t;

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        DRAIN  = 2'b01,
        LOWPWR = 2'b10,
        WAKE   = 2'b11
    } lp_state_t;

    // len(4) + size(3) + burst(2) + lock(2) + cache(4) + prot(3)
    localparam int unsigned c_AX_CTRL_BITS = 18;

    function automatic int unsigned aw_bits(input int unsigned addr_w, input int unsigned id_w);
        return id_w + addr_w + c_AX_CTRL_BITS;
    endfunction

    function automatic int unsigned ar_bits(input int unsigned addr_w, input int unsigned id_w);
        return id_w + addr_w + c_AX_CTRL_BITS;
    endfunction

    function automatic int unsigned w_bits(input int unsigned n_bytes, input int unsigned id_w);
        return id_w + 9 * n_bytes + 1;
    endfunction

    function automatic int unsigned b_bits(input int unsigned id_w);
        return id_w + 2;
    endfunction

    function automatic int unsigned r_bits(input int unsigned n_bytes, input int unsigned id_w);
        return id_w + 8 * n_bytes + 3;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi3_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : axi3_if                                                    |
// | Purpose  : AXI3 five-channel bundle plus low-power handshake signals. |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
interface axi3_if
    import axi3_pkg::*;
#(
    parameter int unsigned N_BYTES    = 4,
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned ID_WIDTH   = 4
) ();
    logic [ID_WIDTH-1:0]   AWID;
    logic [ADDR_WIDTH-1:0] AWADDR;
    logic [3:0]            AWLEN;
    logic [2:0]            AWSIZE;
    burst_t                AWBURST;
    lock_t                 AWLOCK;
    logic [3:0]            AWCACHE;
    logic [2:0]            AWPROT;
    logic                  AWVALID;
    logic                  AWREADY;

    logic [ID_WIDTH-1:0]   WID;
    logic [8*N_BYTES-1:0]  WDATA;
    logic [N_BYTES-1:0]    WSTRB;
    logic                  WLAST;
    logic                  WVALID;
    logic                  WREADY;

    logic [ID_WIDTH-1:0]   BID;
    resp_t                 BRESP;
    logic                  BVALID;
    logic                  BREADY;

    logic [ID_WIDTH-1:0]   ARID;
    logic [ADDR_WIDTH-1:0] ARADDR;
    logic [3:0]            ARLEN;
    logic [2:0]            ARSIZE;
    burst_t                ARBURST;
    lock_t                 ARLOCK;
    logic [3:0]            ARCACHE;
    logic [2:0]            ARPROT;
    logic                  ARVALID;
    logic                  ARREADY;

    logic [ID_WIDTH-1:0]   RID;
    logic [8*N_BYTES-1:0]  RDATA;
    resp_t                 RRESP;
    logic                  RLAST;
    logic                  RVALID;
    logic                  RREADY;

    logic                  CSYSREQ;
    logic                  CSYSACK;
    logic                  CSYSACTIVE;

    modport slave (
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT, AWVALID,
        output AWREADY,
        input  WID, WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BID, BRESP, BVALID,
        input  BREADY,
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARVALID,
        output ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID,
        input  RREADY
    );

    modport master (
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT, AWVALID,
        input  AWREADY,
        output WID, WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BID, BRESP, BVALID,
        output BREADY,
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARVALID,
        input  ARREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID,
        output RREADY
    );

    modport peripheral (
        input  CSYSREQ,
        output CSYSACK, CSYSACTIVE
    );

endinterface
`default_nettype wire

// File: rtl/axi_chan_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : axi_chan_fifo                                              |
// | Purpose  : valid/ready buffer: DEPTH 0 wire, 1 skid slice, else FIFO. |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
module axi_chan_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign o_valid = i_valid;
            assign o_ready = i_ready;
            assign o_data  = i_data;
            assign o_empty = 1'b1;
        end else if (DEPTH == 1) begin : g_slice
            logic [WIDTH-1:0] data_q, data_d, skid_q, skid_d;
            logic             valid_q, valid_d, skid_valid_q, skid_valid_d, ready_q, ready_d;

            // Skid register absorbs the beat accepted while the output stalls,
            // which keeps READY registered without losing throughput.
            always_comb begin
                data_d       = data_q;
                valid_d      = valid_q;
                skid_d       = skid_q;
                skid_valid_d = skid_valid_q;
                if (!valid_q || i_ready) begin
                    if (skid_valid_q) begin
                        data_d       = skid_q;
                        valid_d      = 1'b1;
                        skid_valid_d = 1'b0;
                    end else begin
                        data_d  = i_data;
                        valid_d = i_valid && ready_q;
                    end
                end else if (i_valid && ready_q) begin
                    skid_d       = i_data;
                    skid_valid_d = 1'b1;
                end
                ready_d = !skid_valid_d;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_q       <= '0;
                    skid_q       <= '0;
                    valid_q      <= 1'b0;
                    skid_valid_q <= 1'b0;
                    ready_q      <= 1'b0;
                end else begin
                    data_q       <= data_d;
                    skid_q       <= skid_d;
                    valid_q      <= valid_d;
                    skid_valid_q <= skid_valid_d;
                    ready_q      <= ready_d;
                end
            end

            assign o_valid = valid_q;
            assign o_ready = ready_q;
            assign o_data  = data_q;
            assign o_empty = !valid_q && !skid_valid_q;
        end else begin : g_fifo
            localparam int unsigned     c_PTR_W = $clog2(DEPTH);
            localparam logic [c_PTR_W:0] c_FULL = (c_PTR_W + 1)'(DEPTH);

            logic [WIDTH-1:0]   mem_q [DEPTH];
            logic [WIDTH-1:0]   mem_d [DEPTH];
            logic [c_PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
            logic [c_PTR_W:0]   count_q, count_d;
            logic               init_q, init_d;
            logic               w_push, w_pop;

            // init_q holds READY low through reset and rises one edge after release.
            assign o_ready = init_q && (count_q != c_FULL);
            assign o_valid = (count_q != '0);
            assign o_data  = mem_q[rd_ptr_q];
            assign o_empty = (count_q == '0);
            assign w_push  = i_valid && o_ready;
            assign w_pop   = o_valid && i_ready;

            always_comb begin
                mem_d    = mem_q;
                wr_ptr_d = wr_ptr_q;
                rd_ptr_d = rd_ptr_q;
                count_d  = count_q;
                init_d   = 1'b1;
                if (w_push) begin
                    mem_d[wr_ptr_q] = i_data;
                    wr_ptr_d        = wr_ptr_q + 1'b1;
                end
                if (w_pop) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                end
                if (w_push && !w_pop) begin
                    count_d = count_q + 1'b1;
                end else if (w_pop && !w_push) begin
                    count_d = count_q - 1'b1;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                    count_q  <= '0;
                    init_q   <= 1'b0;
                end else begin
                    wr_ptr_q <= wr_ptr_d;
                    rd_ptr_q <= rd_ptr_d;
                    count_q  <= count_d;
                    init_q   <= init_d;
                end
            end

            always_ff @(posedge clk) begin
                mem_q <= mem_d;
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/axi3_channel_buffer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : axi3_channel_buffer                                        |
// | Purpose  : per-channel AXI3 elastic buffer; AXI3_BUF_LOWPOWER_EN adds |
// |            outstanding counters and a CSYSREQ/CSYSACK drain FSM.      |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
module axi3_channel_buffer
    import axi3_pkg::*;
#(
    parameter int unsigned N_BYTES    = 4,
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned AW_DEPTH   = 2,
    parameter int unsigned W_DEPTH    = 2,
    parameter int unsigned B_DEPTH    = 2,
    parameter int unsigned AR_DEPTH   = 2,
    parameter int unsigned R_DEPTH    = 2,
    parameter int unsigned MAX_OUTST  = 16
) (
    input  logic       ACLK,
    input  logic       ARESETn,
    axi3_if.slave      s_axi,
    axi3_if.master     m_axi,
    output logic       idle
`ifdef AXI3_BUF_LOWPOWER_EN
    ,
    axi3_if.peripheral lp
`endif
);

    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [ADDR_WIDTH-1:0] addr;
        logic [3:0]            len;
        logic [2:0]            size;
        burst_t                burst;
        lock_t                 lock;
        logic [3:0]            cache;
        logic [2:0]            prot;
    } ax_t;

    typedef struct packed {
        logic [ID_WIDTH-1:0]  id;
        logic [8*N_BYTES-1:0] data;
        logic [N_BYTES-1:0]   strb;
        logic                 last;
    } w_t;

    typedef struct packed {
        logic [ID_WIDTH-1:0] id;
        resp_t               resp;
    } b_t;

    typedef struct packed {
        logic [ID_WIDTH-1:0]  id;
        logic [8*N_BYTES-1:0] data;
        resp_t                resp;
        logic                 last;
    } r_t;

    ax_t        w_aw_in, w_aw_out, w_ar_in, w_ar_out;
    w_t         w_w_in, w_w_out;
    b_t         w_b_in, w_b_out;
    r_t         w_r_in, w_r_out;
    logic       w_aw_fifo_ready, w_ar_fifo_ready, w_aw_accept, w_ar_accept;
    logic [4:0] w_empty;
    logic       w_fifos_empty;

    assign w_aw_in = '{id: s_axi.AWID, addr: s_axi.AWADDR, len: s_axi.AWLEN, size: s_axi.AWSIZE,
                       burst: s_axi.AWBURST, lock: s_axi.AWLOCK, cache: s_axi.AWCACHE, prot: s_axi.AWPROT};
    assign w_ar_in = '{id: s_axi.ARID, addr: s_axi.ARADDR, len: s_axi.ARLEN, size: s_axi.ARSIZE,
                       burst: s_axi.ARBURST, lock: s_axi.ARLOCK, cache: s_axi.ARCACHE, prot: s_axi.ARPROT};
    assign w_w_in  = '{id: s_axi.WID, data: s_axi.WDATA, strb: s_axi.WSTRB, last: s_axi.WLAST};
    assign w_b_in  = '{id: m_axi.BID, resp: m_axi.BRESP};
    assign w_r_in  = '{id: m_axi.RID, data: m_axi.RDATA, resp: m_axi.RRESP, last: m_axi.RLAST};

    assign m_axi.AWID    = w_aw_out.id;
    assign m_axi.AWADDR  = w_aw_out.addr;
    assign m_axi.AWLEN   = w_aw_out.len;
    assign m_axi.AWSIZE  = w_aw_out.size;
    assign m_axi.AWBURST = w_aw_out.burst;
    assign m_axi.AWLOCK  = w_aw_out.lock;
    assign m_axi.AWCACHE = w_aw_out.cache;
    assign m_axi.AWPROT  = w_aw_out.prot;
    assign m_axi.ARID    = w_ar_out.id;
    assign m_axi.ARADDR  = w_ar_out.addr;
    assign m_axi.ARLEN   = w_ar_out.len;
    assign m_axi.ARSIZE  = w_ar_out.size;
    assign m_axi.ARBURST = w_ar_out.burst;
    assign m_axi.ARLOCK  = w_ar_out.lock;
    assign m_axi.ARCACHE = w_ar_out.cache;
    assign m_axi.ARPROT  = w_ar_out.prot;
    assign m_axi.WID     = w_w_out.id;
    assign m_axi.WDATA   = w_w_out.data;
    assign m_axi.WSTRB   = w_w_out.strb;
    assign m_axi.WLAST   = w_w_out.last;
    assign s_axi.BID     = w_b_out.id;
    assign s_axi.BRESP   = w_b_out.resp;
    assign s_axi.RID     = w_r_out.id;
    assign s_axi.RDATA   = w_r_out.data;
    assign s_axi.RRESP   = w_r_out.resp;
    assign s_axi.RLAST   = w_r_out.last;

    // Address channels are gated at the input so a held-off request never enters the buffer.
    assign s_axi.AWREADY = w_aw_fifo_ready && w_aw_accept;
    assign s_axi.ARREADY = w_ar_fifo_ready && w_ar_accept;
    assign w_fifos_empty = &w_empty;

    axi_chan_fifo #(.WIDTH(aw_bits(ADDR_WIDTH, ID_WIDTH)), .DEPTH(AW_DEPTH)) u_aw_fifo (
        .clk(ACLK), .rst_n(ARESETn), .i_valid(s_axi.AWVALID && w_aw_accept), .o_ready(w_aw_fifo_ready),
        .i_data(w_aw_in), .o_valid(m_axi.AWVALID), .i_ready(m_axi.AWREADY), .o_data(w_aw_out), .o_empty(w_empty[0]));

    axi_chan_fifo #(.WIDTH(w_bits(N_BYTES, ID_WIDTH)), .DEPTH(W_DEPTH)) u_w_fifo (
        .clk(ACLK), .rst_n(ARESETn), .i_valid(s_axi.WVALID), .o_ready(s_axi.WREADY),
        .i_data(w_w_in), .o_valid(m_axi.WVALID), .i_ready(m_axi.WREADY), .o_data(w_w_out), .o_empty(w_empty[1]));

    axi_chan_fifo #(.WIDTH(b_bits(ID_WIDTH)), .DEPTH(B_DEPTH)) u_b_fifo (
        .clk(ACLK), .rst_n(ARESETn), .i_valid(m_axi.BVALID), .o_ready(m_axi.BREADY),
        .i_data(w_b_in), .o_valid(s_axi.BVALID), .i_ready(s_axi.BREADY), .o_data(w_b_out), .o_empty(w_empty[2]));

    axi_chan_fifo #(.WIDTH(ar_bits(ADDR_WIDTH, ID_WIDTH)), .DEPTH(AR_DEPTH)) u_ar_fifo (
        .clk(ACLK), .rst_n(ARESETn), .i_valid(s_axi.ARVALID && w_ar_accept), .o_ready(w_ar_fifo_ready),
        .i_data(w_ar_in), .o_valid(m_axi.ARVALID), .i_ready(m_axi.ARREADY), .o_data(w_ar_out), .o_empty(w_empty[3]));

    axi_chan_fifo #(.WIDTH(r_bits(N_BYTES, ID_WIDTH)), .DEPTH(R_DEPTH)) u_r_fifo (
        .clk(ACLK), .rst_n(ARESETn), .i_valid(m_axi.RVALID), .o_ready(m_axi.RREADY),
        .i_data(w_r_in), .o_valid(s_axi.RVALID), .i_ready(s_axi.RREADY), .o_data(w_r_out), .o_empty(w_empty[4]));

`ifdef AXI3_BUF_LOWPOWER_EN
    localparam int unsigned           c_OUTST_W   = $clog2(MAX_OUTST + 1);
    localparam logic [c_OUTST_W-1:0] c_OUTST_MAX = c_OUTST_W'(MAX_OUTST);

    lp_state_t            state_q, state_d;
    logic [c_OUTST_W-1:0] wr_outst_q, wr_outst_d, rd_outst_q, rd_outst_d;
    logic                 w_aw_hs, w_b_hs, w_ar_hs, w_rlast_hs, w_sys_ack;

    // Transactions are counted on the downstream side, where they are really in flight.
    assign w_aw_hs    = m_axi.AWVALID && m_axi.AWREADY;
    assign w_b_hs     = m_axi.BVALID && m_axi.BREADY;
    assign w_ar_hs    = m_axi.ARVALID && m_axi.ARREADY;
    assign w_rlast_hs = m_axi.RVALID && m_axi.RREADY && m_axi.RLAST;
    assign idle       = w_fifos_empty && (wr_outst_q == '0) && (rd_outst_q == '0);
    assign lp.CSYSACK    = w_sys_ack;
    assign lp.CSYSACTIVE = w_sys_ack;

    always_comb begin
        state_d     = state_q;
        wr_outst_d  = wr_outst_q;
        rd_outst_d  = rd_outst_q;
        w_sys_ack   = (state_q != LOWPWR);
        w_aw_accept = (state_q == RUN) && (wr_outst_q != c_OUTST_MAX);
        w_ar_accept = (state_q == RUN) && (rd_outst_q != c_OUTST_MAX);
        if (w_aw_hs && !w_b_hs && wr_outst_q != c_OUTST_MAX) begin
            wr_outst_d = wr_outst_q + 1'b1;
        end else if (w_b_hs && !w_aw_hs && wr_outst_q != '0) begin
            wr_outst_d = wr_outst_q - 1'b1;
        end
        if (w_ar_hs && !w_rlast_hs && rd_outst_q != c_OUTST_MAX) begin
            rd_outst_d = rd_outst_q + 1'b1;
        end else if (w_rlast_hs && !w_ar_hs && rd_outst_q != '0) begin
            rd_outst_d = rd_outst_q - 1'b1;
        end
        case (state_q)
            RUN:     if (!lp.CSYSREQ) state_d = DRAIN;
            DRAIN:   if (idle)        state_d = LOWPWR;
            LOWPWR:  if (lp.CSYSREQ)  state_d = WAKE;
            default:                  state_d = RUN;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q    <= RUN;
            wr_outst_q <= '0;
            rd_outst_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_outst_q <= wr_outst_d;
            rd_outst_q <= rd_outst_d;
        end
    end
`else
    assign w_aw_accept = 1'b1;
    assign w_ar_accept = 1'b1;
    assign idle        = w_fifos_empty;
`endif

endmodule
`default_nettype wire
